// File: rtl/store_pkg.sv
// Shared definitions for the store sequencer: size codes, FSM states and
// the read-latency counter width.
package store_pkg;

  localparam logic [1:0] SS_WORD = 2'b00;
  localparam logic [1:0] SS_HALF = 2'b01;
  localparam logic [1:0] SS_BYTE = 2'b10;
  localparam logic [1:0] SS_RSVD = 2'b11;

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/store_merge.sv
// Little-endian lane merge of new store data into the old memory word.
// Word stores pass the new data through; half/byte replace one lane.
module store_merge
  import store_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] merged
);

  // Select the lane(s) replaced by the new data
  always_comb begin
    merged = new_data;
    case (size)
      SS_HALF: merged = lane[1] ? {new_data[15:0], old_word[15:0]}
                                : {old_word[31:16], new_data[15:0]};
      SS_BYTE: begin
        merged = old_word;
        case (lane)
          2'd0:    merged[7:0]   = new_data[7:0];
          2'd1:    merged[15:8]  = new_data[7:0];
          2'd2:    merged[23:16] = new_data[7:0];
          default: merged[31:24] = new_data[7:0];
        endcase
      end
      default: merged = new_data;
    endcase
  end

endmodule

// File: rtl/store_sequencer.sv
// Multicycle SW/SH/SB store controller: direct write for words,
// read-modify-write for sub-word stores, one-cycle done pulse.
// Optional macro STORE_ALIGN_CHECK_EN adds misalignment detection and the
// exc_misalign output.
module store_sequencer
  import store_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  ss_crtl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata
`ifdef STORE_ALIGN_CHECK_EN
  ,
  output logic        exc_misalign
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_RD_LAT - 1);

  state_t           state;
  logic [1:0]       size_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      old_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      merged;

`ifdef STORE_ALIGN_CHECK_EN
  logic misaligned;
  logic mis_q;

  // Word needs addr[1:0]==0, half needs addr[0]==0
  always_comb begin
    misaligned = ((ss_crtl == SS_HALF) && addr[0]) ||
                 ((ss_crtl == SS_WORD) && (addr[1:0] != 2'b00));
  end
`endif

  // Store FSM with captured request and read-latency wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      cnt     <= '0;
`ifdef STORE_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            size_q  <= ss_crtl;
            addr_q  <= addr;
            wdata_q <= wdata;
`ifdef STORE_ALIGN_CHECK_EN
            mis_q   <= misaligned;
            if (misaligned) begin
              state <= ST_DONE;
            end else
`endif
            case (ss_crtl)
              SS_WORD: state <= ST_WRITE;
              SS_HALF, SS_BYTE: begin
                state <= ST_READ;
                cnt   <= CNT_INIT;
              end
              default: state <= ST_DONE;
            endcase
          end
        end
        ST_READ: begin
          if (cnt == '0) begin
            old_q <= mem_rdata;
            state <= ST_WRITE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WRITE: state <= ST_DONE;
        default:  begin
          state <= ST_IDLE;
`ifdef STORE_ALIGN_CHECK_EN
          mis_q <= 1'b0;
`endif
        end
      endcase
    end
  end

  store_merge u_merge (
    .size     (size_q),
    .lane     (addr_q[1:0]),
    .old_word (old_q),
    .new_data (wdata_q),
    .merged   (merged)
  );

  // Outputs decoded from state and registers only
  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    mem_wr    = (state == ST_WRITE);
    mem_addr  = ((state == ST_READ) || (state == ST_WRITE)) ? {addr_q[31:2], 2'b00} : '0;
    mem_wdata = (state == ST_WRITE) ? merged : '0;
`ifdef STORE_ALIGN_CHECK_EN
    exc_misalign = (state == ST_DONE) && mis_q;
`endif
  end

endmodule

// File: tb/tb_store_sequencer.sv
// Scoreboard bench for store_sequencer: the driver pushes the expected
// write/done events per store, a monitor pops and compares them.
module tb_store_sequencer;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  ss_crtl = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic        busy, done, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
`ifdef STORE_ALIGN_CHECK_EN
  logic        exc_misalign;
`endif

  always #5 clk = ~clk;

  store_sequencer #(.MEM_RD_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ss_crtl   (ss_crtl),
    .addr      (addr),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata)
`ifdef STORE_ALIGN_CHECK_EN
    ,
    .exc_misalign (exc_misalign)
`endif
  );

  typedef struct {
    bit          has_write;
    logic [31:0] waddr;
    logic [31:0] wdat;
    int          wcyc;
    int          dcyc;
    bit          exc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] dut_mem [1024];
  logic [31:0] ref_mem [1024];
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  int          rd_age = 0;
  bit          wr_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Memory that the DUT writes into; cycle counter
  always @(posedge clk) begin
    cyc++;
    if (mem_wr) dut_mem[mem_addr[11:2]] <= mem_wdata;
  end

  // Read data is only valid once the same read address has been held LAT cycles
  always @(negedge clk) begin
    if (mem_addr != 0 && !mem_wr) rd_age++;
    else rd_age = 0;
    mem_rdata = (rd_age >= LAT) ? dut_mem[mem_addr[11:2]] : 32'hBAD0_BAD0;
  end

  // Monitor: compare writes and done pulses against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wr) begin
        if (exp_q.size() == 0 || wr_seen || !exp_q[0].has_write) fail_now("unexpected_write");
        else begin
          check("wr_cycle", cyc, exp_q[0].wcyc);
          check("wr_addr", mem_addr, exp_q[0].waddr);
          check("wr_data", mem_wdata, exp_q[0].wdat);
          wr_seen = 1;
        end
      end
      if (done) begin
        if (exp_q.size() == 0) fail_now("unexpected_done");
        else begin
          check("done_cycle", cyc, exp_q[0].dcyc);
          check("write_seen", 32'(wr_seen), 32'(exp_q[0].has_write));
`ifdef STORE_ALIGN_CHECK_EN
          check("exc_misalign", 32'(exc_misalign), 32'(exp_q[0].exc));
`endif
          void'(exp_q.pop_front());
          wr_seen = 0;
        end
      end
`ifdef STORE_ALIGN_CHECK_EN
      if (exc_misalign && !done) fail_now("exc_without_done");
`endif
    end
  end

  // Reference lane merge from plain mask arithmetic
  function automatic logic [31:0] ref_merge(input logic [1:0] code, input logic [31:0] a,
                                            input logic [31:0] d, input logic [31:0] old);
    int          sh;
    logic [31:0] m;
    if (code == 2'b01) begin
      sh = int'(a[1]) * 16;
      m  = 32'h0000_FFFF << sh;
      return (old & ~m) | ((d & 32'h0000_FFFF) << sh);
    end else if (code == 2'b10) begin
      sh = int'(a[1:0]) * 8;
      m  = 32'h0000_00FF << sh;
      return (old & ~m) | ((d & 32'h0000_00FF) << sh);
    end
    return d;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_now("idle_timeout");
  endtask

  // Drive one store from a negedge and record what it must produce
  task automatic issue(input logic [1:0] code, input logic [31:0] a, input logic [31:0] d,
                       input bit poke);
    exp_t e;
    bit   mis;
    int   idx;
    wait_idle();
    mis = 0;
`ifdef STORE_ALIGN_CHECK_EN
    mis = (code == 2'b01 && a[0]) || (code == 2'b00 && a[1:0] != 2'b00);
`endif
    idx         = int'(a[11:2]);
    e.exc       = mis;
    e.has_write = !(mis || code == 2'b11);
    e.waddr     = a & 32'hFFFF_FFFC;
    e.wdat      = ref_merge(code, a, d, ref_mem[idx]);
    e.wcyc      = cyc + 1 + ((code == 2'b00) ? 0 : int'(LAT));
    e.dcyc      = e.has_write ? e.wcyc + 1 : cyc + 1;
    if (e.has_write) ref_mem[idx] = e.wdat;
    exp_q.push_back(e);
    start   = 1'b1;
    ss_crtl = code;
    addr    = a;
    wdata   = d;
    @(negedge clk);
    ss_crtl = 2'($urandom);
    addr    = $urandom;
    wdata   = $urandom;
    if (poke) @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          n;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      dut_mem[i] = v;
      ref_mem[i] = v;
    end
    dut_mem[10'h080] = 32'h1122_3344;
    ref_mem[10'h080] = 32'h1122_3344;
    dut_mem[10'h0C0] = 32'h1122_3344;
    ref_mem[10'h0C0] = 32'h1122_3344;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_mem_wr", 32'(mem_wr), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;

    // Directed stores
    issue(2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 0);
    issue(2'b10, 32'h0000_0203, 32'h0000_00AA, 0);
    issue(2'b01, 32'h0000_0302, 32'hFFFF_5566, 1);
    issue(2'b11, 32'h0000_0404, 32'h1234_5678, 1);
    issue(2'b00, 32'h0000_0102, 32'hCAFE_F00D, 0);
    issue(2'b01, 32'h0000_0101, 32'h0000_BEEF, 0);

    // Randomized stores, sometimes poking start while busy
    for (int i = 0; i < 40; i++)
      issue(2'($urandom), ($urandom & 32'hFFFF_F000) | (32'h100 + ($urandom % 32'hF00)),
            $urandom, bit'($urandom));

    // Reset during the READ phase of a byte store abandons it
    wait_idle();
    start   = 1'b1;
    ss_crtl = 2'b10;
    addr    = 32'h0000_0500;
    wdata   = 32'h0000_0077;
    @(negedge clk);
    start = 1'b0;
    check("mid_busy_before", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_mem_wr", 32'(mem_wr), 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b00, 32'h0000_0600, 32'h0BAD_CAFE, 0);
    issue(2'b10, 32'h0000_0500, 32'h0000_0042, 0);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    check("mem_abort_word", dut_mem[10'h140], ref_mem[10'h140]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
